// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the pipeline.
// It accepts one load or store at a time, waits LATENCY cycles, and then
// performs the access on a little-endian word array. A response is returned
// over a valid/ready channel.
module dmem_responder #(
    parameter int                DATAW       = 32,
    parameter int                ADDRW       = 32,
    parameter logic [ADDRW-1:0]  BASE_ADDR   = 32'h01000000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int               IW       = $clog2(DEPTH_WORDS);
    localparam int               CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int               LAST     = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [CW-1:0]    LAST_CNT = CW'(LAST);
    localparam logic [ADDRW:0]   SPAN     = (ADDRW+1)'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             live_reg;
    logic             we_reg, uns_reg, err_reg;
    logic [1:0]       size_reg;
    logic [ADDRW-1:0] addr_reg;
    logic [DATAW-1:0] wdata_reg;
    logic [DATAW-1:0] mem [DEPTH_WORDS];
    logic [DATAW-1:0] mem_q_reg;

    logic             accept, commit, wr_en;
    logic             cur_we, cur_err;
    logic [1:0]       cur_size, lane;
    logic [ADDRW-1:0] cur_addr, offset;
    logic [DATAW-1:0] cur_wdata, lane_wdata, shifted, load_val;
    logic [3:0]       lane_be;
    logic [IW-1:0]    idx;

    assign accept = req_valid && req_ready;

    // In IDLE the commit can only be the zero-latency case, so it uses the live inputs.
    assign cur_we    = (state_reg == S_IDLE) ? req_we    : we_reg;
    assign cur_size  = (state_reg == S_IDLE) ? req_size  : size_reg;
    assign cur_addr  = (state_reg == S_IDLE) ? req_addr  : addr_reg;
    assign cur_wdata = (state_reg == S_IDLE) ? req_wdata : wdata_reg;

    assign offset  = cur_addr - BASE_ADDR;
    assign idx     = offset[IW+1:2];
    assign lane    = cur_addr[1:0];
    assign cur_err = (cur_size == 2'b11)
                  || (cur_size == 2'b01 && cur_addr[0])
                  || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
                  || (cur_addr < BASE_ADDR)
                  || ({1'b0, offset} >= SPAN);
    assign wr_en   = commit && cur_we && !cur_err;

    // Byte-lane enables and replicated store data for each of the four lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_be[gi] = (cur_size == 2'b10)
                          || (cur_size == 2'b00 && lane == 2'(gi))
                          || (cur_size == 2'b01 && (lane == 2'(gi) || 2'(lane + 2'd1) == 2'(gi)));
        assign lane_wdata[gi*8 +: 8] = (cur_size == 2'b00) ? cur_wdata[7:0] :
                                       (cur_size == 2'b01) ? cur_wdata[(gi%2)*8 +: 8] :
                                                             cur_wdata[gi*8 +: 8];
    end

    // State register, wait counter, latched request and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            live_reg  <= 1'b0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            size_reg  <= 2'b00;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            live_reg  <= 1'b1;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                size_reg  <= req_size;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
            end
            if (commit)
                err_reg <= cur_err;
            else if (state_reg == S_RESP && rsp_ready)
                err_reg <= 1'b0;
        end
    end

    // Next-state logic; commit marks the edge that enters RESP.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        commit     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        count_next = '0;
                    end
                end
            end
            S_WAIT: begin
                if (count_reg == LAST_CNT) begin
                    state_next = S_RESP;
                    commit     = 1'b1;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Array: byte-lane writes and registered read, both at the commit edge.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++)
                if (lane_be[i])
                    mem[idx][i*8 +: 8] <= lane_wdata[i*8 +: 8];
        end
        if (commit)
            mem_q_reg <= mem[idx];
    end

    // Extract and extend the loaded lanes from the registered read word.
    always_comb begin
        shifted  = mem_q_reg >> {addr_reg[1:0], 3'b000};
        load_val = shifted;
        case (size_reg)
            2'b00:   load_val = uns_reg ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_reg ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign req_ready = (state_reg == S_IDLE) && live_reg;
    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_err   = err_reg;
    assign rsp_rdata = (rsp_valid && !err_reg && !we_reg) ? load_val : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: three instances (LATENCY 2, 0, 5)
// share the request fields, and a selector routes handshakes to one of them.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    int          sel;
    int          n_vec = 0;
    int          n_bad = 0;

    logic        qr0, qr1, qr2, rv0, rv1, rv2, re0, re1, re2;
    logic [31:0] rd0, rd1, rd2;
    logic        cur_qr, cur_rv, cur_re;
    logic [31:0] cur_rd;
    int          exp_lat;

    always #5 clock = ~clock;

    dmem_responder #(.LATENCY(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel == 0), .req_ready(qr0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_ready(rsp_ready && sel == 0),
        .rsp_rdata(rd0), .rsp_err(re0)
    );

    dmem_responder #(.LATENCY(0)) dut_l0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel == 1), .req_ready(qr1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready && sel == 1),
        .rsp_rdata(rd1), .rsp_err(re1)
    );

    dmem_responder #(.LATENCY(5)) dut_l5 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid && sel == 2), .req_ready(qr2),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_ready(rsp_ready && sel == 2),
        .rsp_rdata(rd2), .rsp_err(re2)
    );

    // Route the selected instance's outputs to the checker.
    always_comb begin
        cur_qr = qr0; cur_rv = rv0; cur_re = re0; cur_rd = rd0; exp_lat = 3;
        case (sel)
            1: begin cur_qr = qr1; cur_rv = rv1; cur_re = re1; cur_rd = rd1; exp_lat = 1; end
            2: begin cur_qr = qr2; cur_rv = rv2; cur_re = re2; cur_rd = rd2; exp_lat = 6; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One request/response transaction on the selected instance.
    task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n;
        @(negedge clock);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        chk({tag, ".ready_idle"}, 32'(cur_qr), 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk({tag, ".ready_busy"}, 32'(cur_qr), 32'd0);
        n = 1;
        while (!cur_rv && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rdata"}, cur_rd, exp_rd);
        chk({tag, ".err"}, 32'(cur_re), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            chk({tag, ".hold_valid"}, 32'(cur_rv), 32'd1);
            chk({tag, ".hold_rdata"}, cur_rd, exp_rd);
            chk({tag, ".hold_ready"}, 32'(cur_qr), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        chk({tag, ".valid_after"}, 32'(cur_rv), 32'd0);
        chk({tag, ".ready_after"}, 32'(cur_qr), 32'd1);
        $display("xact %s we=%b size=%b addr=%h lat=%0d", tag, we, sz, addr, n);
    endtask

    initial begin
        sel = 0;
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        #12;
        chk("rst.req_ready", 32'(qr0), 32'd0);
        chk("rst.rsp_valid", 32'(rv0), 32'd0);
        chk("rst.rsp_rdata", rd0, 32'd0);
        chk("rst.rsp_err", 32'(re0), 32'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("rst.ready_release", 32'(qr0), 32'd1);

        // Word store and readback.
        xact("sw0",  1'b1, 2'b10, 1'b0, 32'h01000000, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        xact("lw0",  1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Sub-word stores and extension.
        xact("sw4",  1'b1, 2'b10, 1'b0, 32'h01000004, 32'h0, 32'h0, 1'b0, 0);
        xact("sb5",  1'b1, 2'b00, 1'b0, 32'h01000005, 32'h00000080, 32'h0, 1'b0, 0);
        xact("lb5",  1'b0, 2'b00, 1'b0, 32'h01000005, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        xact("lbu5", 1'b0, 2'b00, 1'b1, 32'h01000005, 32'h0, 32'h00000080, 1'b0, 0);
        xact("lw4",  1'b0, 2'b10, 1'b0, 32'h01000004, 32'h0, 32'h00008000, 1'b0, 0);
        xact("lh4",  1'b0, 2'b01, 1'b0, 32'h01000004, 32'h0, 32'hFFFF8000, 1'b0, 0);
        xact("lhu4", 1'b0, 2'b01, 1'b1, 32'h01000004, 32'h0, 32'h00008000, 1'b0, 0);
        xact("sh6",  1'b1, 2'b01, 1'b0, 32'h01000006, 32'h0000A5B6, 32'h0, 1'b0, 0);
        xact("lw4b", 1'b0, 2'b10, 1'b0, 32'h01000004, 32'h0, 32'hA5B68000, 1'b0, 0);
        xact("lbu7", 1'b0, 2'b00, 1'b1, 32'h01000007, 32'h0, 32'h000000A5, 1'b0, 0);
        xact("lb6",  1'b0, 2'b00, 1'b0, 32'h01000006, 32'h0, 32'hFFFFFFB6, 1'b0, 0);

        // Error cases and range boundaries.
        xact("lh3",   1'b0, 2'b01, 1'b0, 32'h01000003, 32'h0, 32'h0, 1'b1, 0);
        xact("swlow", 1'b1, 2'b10, 1'b0, 32'h00FFFFFC, 32'h55555555, 32'h0, 1'b1, 0);
        xact("lw0b",  1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        xact("sz11",  1'b0, 2'b11, 1'b0, 32'h01000000, 32'h0, 32'h0, 1'b1, 0);
        xact("swhi",  1'b1, 2'b10, 1'b0, 32'h01001000, 32'h66666666, 32'h0, 1'b1, 0);
        xact("swtop", 1'b1, 2'b10, 1'b0, 32'h01000FFC, 32'h12345678, 32'h0, 1'b0, 0);
        xact("lwtop", 1'b0, 2'b10, 1'b0, 32'h01000FFC, 32'h0, 32'h12345678, 1'b0, 0);
        xact("lwmis", 1'b0, 2'b10, 1'b0, 32'h01000002, 32'h0, 32'h0, 1'b1, 0);

        // Response back-pressure.
        xact("hold",  1'b0, 2'b10, 1'b0, 32'h01000000, 32'h0, 32'hDEADBEEF, 1'b0, 5);

        // Reset during WAIT drops the uncommitted store.
        xact("sw8",   1'b1, 2'b10, 1'b0, 32'h01000008, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        @(negedge clock);
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h01000008; req_wdata = 32'h11223344;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("abort.wait_valid", 32'(rv0), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort.req_ready", 32'(qr0), 32'd0);
        chk("abort.rsp_valid", 32'(rv0), 32'd0);
        chk("abort.rsp_rdata", rd0, 32'd0);
        chk("abort.rsp_err", 32'(re0), 32'd0);
        $display("xact abort store addr=01000008 by reset");
        @(negedge clock); @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("abort.ready_release", 32'(qr0), 32'd1);
        xact("lw8",   1'b0, 2'b10, 1'b0, 32'h01000008, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        // Latency sweep on the LATENCY=0 and LATENCY=5 instances.
        sel = 1;
        xact("l0.sw", 1'b1, 2'b10, 1'b0, 32'h01000010, 32'h0BADF00D, 32'h0, 1'b0, 0);
        xact("l0.lw", 1'b0, 2'b10, 1'b0, 32'h01000010, 32'h0, 32'h0BADF00D, 1'b0, 0);
        xact("l0.sb", 1'b1, 2'b00, 1'b0, 32'h01000011, 32'h000000EE, 32'h0, 1'b0, 0);
        xact("l0.lw2",1'b0, 2'b10, 1'b0, 32'h01000010, 32'h0, 32'h0BADEE0D, 1'b0, 0);
        xact("l0.err",1'b1, 2'b01, 1'b0, 32'h01000011, 32'h0000FFFF, 32'h0, 1'b1, 0);
        sel = 2;
        xact("l5.sw", 1'b1, 2'b10, 1'b0, 32'h01000010, 32'h55AA33CC, 32'h0, 1'b0, 0);
        xact("l5.lw", 1'b0, 2'b10, 1'b0, 32'h01000010, 32'h0, 32'h55AA33CC, 1'b0, 0);
        xact("l5.lh", 1'b0, 2'b01, 1'b0, 32'h01000012, 32'h0, 32'h000055AA, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
